// File: rtl/stream_mux_pkg.sv
// Shared constants for the packet-aware stream multiplexer: arbitration
// modes and FSM state encoding.
package stream_mux_pkg;

  // Arbitration modes, also used as the arbiter's mode input
  localparam logic [1:0] MODE_RR    = 2'd0;
  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_SEL   = 2'd2;

  // FSM states: free arbitration, or output held by one channel mid-packet
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Request arbiter for the stream mux. One combinational block covers all
// three policies:
//   round-robin: first request at or above ptr, otherwise lowest (wrap)
//   fixed:       lowest-index request
//   select:      only the request at index ptr (no grant if ptr >= N_CH)
// The top also uses select mode with ptr = locked channel while a packet
// is in flight.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SELW = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  input  logic [1:0]      mode_i,
  output logic [N_CH-1:0] grant_o,
  output logic [SELW-1:0] idx_o,
  output logic            valid_o
);

  logic [N_CH-1:0] grant;
  logic [SELW-1:0] idx;
  logic            found;

  // Two-pass priority search: upper pass honours ptr, lower pass wraps
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req_i[i] &&
          (((mode_i == MODE_RR) && (i >= int'(ptr_i))) ||
           ((mode_i == MODE_SEL) && (i == int'(ptr_i))))) begin
        grant[i] = 1'b1;
        idx      = SELW'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req_i[i] && (mode_i != MODE_SEL)) begin
        grant[i] = 1'b1;
        idx      = SELW'(i);
        found    = 1'b1;
      end
    end
  end

  assign grant_o = grant;
  assign idx_o   = idx;
  assign valid_o = found;

endmodule

// File: rtl/stream_mux_arb.sv
// N_CH-channel valid/ready stream mux with a registered output stage.
// A channel that starts a multi-beat packet keeps the output until its
// last beat is accepted; arbitration policy is chosen by MODE.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  WIDTH = 8,
  parameter int  MODE  = 0,
  localparam int SELW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  input  logic [SELW-1:0]       sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SELW-1:0]       out_ch,
  input  logic                  out_ready
);

  localparam logic [1:0] TopMode = MODE[1:0];

  logic [0:0]       state_q, state_d;
  logic [SELW-1:0]  lockCh_q, lockCh_d;
  logic [SELW-1:0]  rrPtr_q, rrPtr_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic             outLast_q, outLast_d;
  logic [SELW-1:0]  outCh_q, outCh_d;

  logic [1:0]       arbMode;
  logic [SELW-1:0]  arbPtr;
  logic [N_CH-1:0]  grant;
  logic [SELW-1:0]  grantIdx;
  logic             grantValid;
  logic             stageFree;
  logic             accept;
  logic [WIDTH-1:0] beatData;
  logic             beatLast;

  // While locked, force select mode on the locked channel so others are ignored
  always_comb begin
    if (state_q == ST_LOCK) begin
      arbMode = MODE_SEL;
      arbPtr  = lockCh_q;
    end else begin
      arbMode = TopMode;
      arbPtr  = (TopMode == MODE_SEL) ? sel : rrPtr_q;
    end
  end

  rr_arbiter #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_arb (
    .req_i   (in_valid),
    .ptr_i   (arbPtr),
    .mode_i  (arbMode),
    .grant_o (grant),
    .idx_o   (grantIdx),
    .valid_o (grantValid)
  );

  assign stageFree = !outValid_q || out_ready;
  assign accept    = !rst && stageFree && grantValid;
  assign in_ready  = accept ? grant : '0;

  // Pick the granted channel's beat using the one-hot grant
  always_comb begin
    beatData = '0;
    beatLast = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        beatData = in_data[i*WIDTH +: WIDTH];
        beatLast = in_last[i];
      end
    end
  end

  // Next-state: load output stage on accept, track packet lock and rr pointer
  always_comb begin
    state_d    = state_q;
    lockCh_d   = lockCh_q;
    rrPtr_d    = rrPtr_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    outCh_d    = outCh_q;
    if (accept) begin
      outValid_d = 1'b1;
      outData_d  = beatData;
      outLast_d  = beatLast;
      outCh_d    = grantIdx;
      if (beatLast) begin
        state_d = ST_ARB;
        if (TopMode == MODE_RR) begin
          rrPtr_d = (int'(grantIdx) == N_CH - 1) ? '0 : grantIdx + SELW'(1);
        end
      end else begin
        state_d  = ST_LOCK;
        lockCh_d = grantIdx;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; reset drops any held beat and packet lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ARB;
      lockCh_q   <= '0;
      rrPtr_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outCh_q    <= '0;
    end else begin
      state_q    <= state_d;
      lockCh_q   <= lockCh_d;
      rrPtr_q    <= rrPtr_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
      outCh_q    <= outCh_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign out_ch    = outCh_q;

endmodule
